// File: rtl/uart_device.sv
// Memory-mapped 8N1 UART: 16-bit register interface, one-byte TX holding register,
// 2-flop synchronized receiver feeding a small circular FIFO. Reads are registered.
module uart_device #(
    parameter logic [15:0] DIVISOR_INIT = 16'd104,
    parameter int          RX_DEPTH     = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        write_enable,
    input  logic [15:0] address,
    input  logic [15:0] data_in,
    output logic [15:0] data_out,
    input  logic        rx,
    output logic        tx
);
    localparam int PW = $clog2(RX_DEPTH);
    localparam logic [PW:0] FIFO_FULL = RX_DEPTH[PW:0];

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    logic [15:0] divisor_reg, data_out_reg, read_data;
    logic [7:0]  hold_reg;
    logic        hold_full_reg, overrun_reg, frame_err_reg;

    state_t      tx_state_reg, tx_state_next;
    logic [15:0] tx_cnt_reg, tx_cnt_next;
    logic [2:0]  tx_bit_reg, tx_bit_next;
    logic [7:0]  tx_shift_reg, tx_shift_next;
    logic        tx_reg, tx_next, tx_load;

    logic        rx_meta_reg, rx_sync_reg, rx_prev_reg;
    state_t      rx_state_reg, rx_state_next;
    logic [15:0] rx_cnt_reg, rx_cnt_next;
    logic [2:0]  rx_bit_reg, rx_bit_next;
    logic [7:0]  rx_shift_reg, rx_shift_next;
    logic        rx_push, rx_ferr_set;

    logic [7:0]  rx_mem [RX_DEPTH];
    logic [PW-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [PW:0]   count_reg;

    logic unused_addr;
    assign unused_addr = ^address[15:2];

    wire wr_status = write_enable && (address[1:0] == 2'd0);
    wire wr_txdata = write_enable && (address[1:0] == 2'd1);
    wire wr_rxdata = write_enable && (address[1:0] == 2'd2);
    wire wr_div    = write_enable && (address[1:0] == 2'd3);

    wire        tx_ready = !hold_full_reg;
    wire        tx_busy  = (tx_state_reg != IDLE);
    wire        rx_valid = (count_reg != '0);
    wire        fifo_full = (count_reg == FIFO_FULL);
    wire        pop = wr_rxdata && rx_valid;
    // A push into a full FIFO still succeeds when a pop frees the slot in the same cycle.
    wire        push_ok = rx_push && (!fifo_full || pop);
    wire        overrun_set = rx_push && fifo_full && !pop;
    wire [15:0] div_m1  = divisor_reg - 16'd1;
    wire [15:0] half_m1 = (divisor_reg >> 1) - 16'd1;
    wire        rx_fall = rx_prev_reg && !rx_sync_reg;

    always_comb begin
        read_data = 16'h0000;
        case (address[1:0])
            2'd0: read_data = {8'(count_reg), 3'b000, frame_err_reg, tx_busy,
                               overrun_reg, rx_valid, tx_ready};
            2'd2: read_data = rx_valid ? {8'h00, rx_mem[rd_ptr_reg]} : 16'h0000;
            2'd3: read_data = divisor_reg;
            default: read_data = 16'h0000;
        endcase
    end

    // Transmitter: the bit counter reloads from the live divisor at each bit boundary.
    always_comb begin
        tx_state_next = tx_state_reg;
        tx_cnt_next   = tx_cnt_reg;
        tx_bit_next   = tx_bit_reg;
        tx_shift_next = tx_shift_reg;
        tx_next       = tx_reg;
        tx_load       = 1'b0;
        case (tx_state_reg)
            IDLE: tx_load = hold_full_reg;
            START: begin
                if (tx_cnt_reg == 16'd0) begin
                    tx_state_next = DATA;
                    tx_cnt_next   = div_m1;
                    tx_bit_next   = 3'd0;
                    tx_next       = tx_shift_reg[0];
                end else begin
                    tx_cnt_next = tx_cnt_reg - 16'd1;
                end
            end
            DATA: begin
                if (tx_cnt_reg == 16'd0) begin
                    tx_cnt_next = div_m1;
                    if (tx_bit_reg == 3'd7) begin
                        tx_state_next = STOP;
                        tx_next       = 1'b1;
                    end else begin
                        tx_bit_next   = tx_bit_reg + 3'd1;
                        tx_shift_next = {1'b0, tx_shift_reg[7:1]};
                        tx_next       = tx_shift_reg[1];
                    end
                end else begin
                    tx_cnt_next = tx_cnt_reg - 16'd1;
                end
            end
            STOP: begin
                if (tx_cnt_reg == 16'd0) begin
                    if (hold_full_reg) tx_load = 1'b1;
                    else               tx_state_next = IDLE;
                end else begin
                    tx_cnt_next = tx_cnt_reg - 16'd1;
                end
            end
            default: tx_state_next = IDLE;
        endcase
        if (tx_load) begin
            tx_state_next = START;
            tx_shift_next = hold_reg;
            tx_cnt_next   = div_m1;
            tx_next       = 1'b0;
        end
    end

    // Receiver: samples land mid-bit, DIVISOR/2 after the detected falling edge.
    always_comb begin
        rx_state_next = rx_state_reg;
        rx_cnt_next   = rx_cnt_reg;
        rx_bit_next   = rx_bit_reg;
        rx_shift_next = rx_shift_reg;
        rx_push       = 1'b0;
        rx_ferr_set   = 1'b0;
        case (rx_state_reg)
            IDLE: begin
                if (rx_fall) begin
                    rx_state_next = START;
                    rx_cnt_next   = half_m1;
                end
            end
            START: begin
                if (rx_cnt_reg == 16'd0) begin
                    rx_state_next = rx_sync_reg ? IDLE : DATA;
                    rx_cnt_next   = div_m1;
                    rx_bit_next   = 3'd0;
                end else begin
                    rx_cnt_next = rx_cnt_reg - 16'd1;
                end
            end
            DATA: begin
                if (rx_cnt_reg == 16'd0) begin
                    rx_shift_next = {rx_sync_reg, rx_shift_reg[7:1]};
                    rx_cnt_next   = div_m1;
                    rx_bit_next   = rx_bit_reg + 3'd1;
                    if (rx_bit_reg == 3'd7) rx_state_next = STOP;
                end else begin
                    rx_cnt_next = rx_cnt_reg - 16'd1;
                end
            end
            STOP: begin
                if (rx_cnt_reg == 16'd0) begin
                    rx_state_next = IDLE;
                    rx_push       = rx_sync_reg;
                    rx_ferr_set   = !rx_sync_reg;
                end else begin
                    rx_cnt_next = rx_cnt_reg - 16'd1;
                end
            end
            default: rx_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            divisor_reg   <= DIVISOR_INIT;
            data_out_reg  <= 16'h0000;
            hold_reg      <= 8'h00;
            hold_full_reg <= 1'b0;
            overrun_reg   <= 1'b0;
            frame_err_reg <= 1'b0;
            tx_state_reg  <= IDLE;
            tx_cnt_reg    <= 16'd0;
            tx_bit_reg    <= 3'd0;
            tx_shift_reg  <= 8'h00;
            tx_reg        <= 1'b1;
            rx_meta_reg   <= 1'b1;
            rx_sync_reg   <= 1'b1;
            rx_prev_reg   <= 1'b1;
            rx_state_reg  <= IDLE;
            rx_cnt_reg    <= 16'd0;
            rx_bit_reg    <= 3'd0;
            rx_shift_reg  <= 8'h00;
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            count_reg     <= '0;
        end else begin
            data_out_reg <= read_data;
            if (wr_div) divisor_reg <= (data_in < 16'd2) ? 16'd2 : data_in;
            if (tx_load) begin
                hold_full_reg <= 1'b0;
            end else if (wr_txdata && tx_ready) begin
                hold_reg      <= data_in[7:0];
                hold_full_reg <= 1'b1;
            end
            if (overrun_set)                    overrun_reg <= 1'b1;
            else if (wr_status && data_in[2])   overrun_reg <= 1'b0;
            if (rx_ferr_set)                    frame_err_reg <= 1'b1;
            else if (wr_status && data_in[4])   frame_err_reg <= 1'b0;
            tx_state_reg <= tx_state_next;
            tx_cnt_reg   <= tx_cnt_next;
            tx_bit_reg   <= tx_bit_next;
            tx_shift_reg <= tx_shift_next;
            tx_reg       <= tx_next;
            rx_meta_reg  <= rx;
            rx_sync_reg  <= rx_meta_reg;
            rx_prev_reg  <= rx_sync_reg;
            rx_state_reg <= rx_state_next;
            rx_cnt_reg   <= rx_cnt_next;
            rx_bit_reg   <= rx_bit_next;
            rx_shift_reg <= rx_shift_next;
            if (push_ok) wr_ptr_reg <= wr_ptr_reg + PW'(1);
            if (pop)     rd_ptr_reg <= rd_ptr_reg + PW'(1);
            count_reg <= count_reg + (PW+1)'(push_ok) - (PW+1)'(pop);
        end
    end

    always_ff @(posedge clock) begin
        if (push_ok) rx_mem[wr_ptr_reg] <= rx_shift_reg;
    end

    assign data_out = data_out_reg;
    assign tx       = tx_reg;
endmodule

// File: tb/tb_uart_device.sv
// Bench for uart_device: queue-based frame/FIFO model checked every cycle, plus
// directed literal checks and randomized register/serial traffic.
module tb_uart_device;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        we = 1'b0;
    logic [15:0] addr = 16'h0000;
    logic [15:0] din = 16'h0000;
    logic        rx = 1'b1;
    wire  [15:0] dout;
    wire         tx_line;

    uart_device #(.DIVISOR_INIT(16'd4), .RX_DEPTH(DEPTH)) dut (
        .clock(clk), .reset(rst_n), .write_enable(we), .address(addr),
        .data_in(din), .data_out(dout), .rx(rx), .tx(tx_line)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Behavioural model: tx line as a queue of per-cycle levels, FIFO as a byte queue.
    logic [15:0] m_div = 16'd4;
    bit          m_hold_full = 0;
    logic [7:0]  m_hold = 8'h00;
    bit          m_line[$];
    bit          m_busy = 0;
    logic [7:0]  m_fifo[$];
    bit          m_ovr = 0, m_ferr = 0;
    int          rx_done_q[$];
    bit          rx_active = 0;
    bit          rx_unc = 0;
    logic [15:0] exp_dout = 16'h0000, exp_mask = 16'hFFFF;
    logic        exp_tx = 1'b1;
    bit          cmp_en = 0;
    logic        we_c;
    logic [1:0]  a_c;
    logic [15:0] d_c;
    bit          hold_before;

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s t=%0t got=%h exp=%h", name, $time, got, exp);
        end
    endtask

    function automatic bit fbit(input logic [7:0] b, input int j);
        if (j == 0) return 1'b0;
        if (j == 9) return 1'b1;
        return b[j-1];
    endfunction

    task automatic model_reset();
        m_div = 16'd4; m_hold_full = 0; m_line.delete(); m_busy = 0;
        m_fifo.delete(); m_ovr = 0; m_ferr = 0;
        exp_dout = 16'h0000; exp_mask = 16'hFFFF; exp_tx = 1'b1;
    endtask

    // Model update: one step per rising edge, using inputs held stable across it.
    initial begin
        forever begin
            @(posedge clk);
            cmp_en = 1;
            if (!rst_n) begin
                model_reset();
                continue;
            end
            we_c = we; a_c = addr[1:0]; d_c = din;
            while (rx_done_q.size() > 0) begin
                int r;
                r = rx_done_q.pop_front();
                if ((r >> 8) == 0) begin
                    if (m_fifo.size() < DEPTH) m_fifo.push_back(r[7:0]);
                    else m_ovr = 1;
                end else if ((r >> 8) == 1) begin
                    m_ferr = 1;
                end
            end
            rx_unc = rx_active;
            case (a_c)
                2'd0: begin
                    exp_dout = {8'(m_fifo.size()), 3'b000, m_ferr, m_busy, m_ovr,
                                (m_fifo.size() != 0), !m_hold_full};
                    exp_mask = rx_unc ? 16'h00E9 : 16'hFFFF;
                end
                2'd1: begin exp_dout = 16'h0000; exp_mask = 16'hFFFF; end
                2'd2: begin
                    exp_dout = (m_fifo.size() != 0) ? {8'h00, m_fifo[0]} : 16'h0000;
                    exp_mask = rx_unc ? 16'h0000 : 16'hFFFF;
                end
                default: begin exp_dout = m_div; exp_mask = 16'hFFFF; end
            endcase
            hold_before = m_hold_full;
            if (m_line.size() == 0 && m_hold_full) begin
                for (int j = 0; j < 10; j++)
                    for (int k = 0; k < int'(m_div); k++) m_line.push_back(fbit(m_hold, j));
                m_hold_full = 0;
            end
            if (m_line.size() != 0) begin
                exp_tx = m_line.pop_front();
                m_busy = 1;
            end else begin
                exp_tx = 1'b1;
                m_busy = 0;
            end
            if (we_c) begin
                case (a_c)
                    2'd0: begin
                        if (d_c[2]) m_ovr = 0;
                        if (d_c[4]) m_ferr = 0;
                    end
                    2'd1: if (!hold_before) begin m_hold = d_c[7:0]; m_hold_full = 1; end
                    2'd2: if (m_fifo.size() != 0) void'(m_fifo.pop_front());
                    default: m_div = (d_c < 16'd2) ? 16'd2 : d_c;
                endcase
            end
        end
    end

    // Compare process: DUT outputs vs model, sampled on the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            if (cmp_en) begin
                check("model_tx", {15'd0, tx_line}, {15'd0, exp_tx});
                if (exp_mask != 16'h0000)
                    check("model_dout", dout & exp_mask, exp_dout & exp_mask);
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr(input logic [1:0] a, input logic [15:0] d);
        addr = (16'($urandom) & 16'hFFFC) | {14'd0, a};
        din = d; we = 1'b1;
        $display("wr  a=%0d d=%h", a, d);
        @(negedge clk);
        we = 1'b0;
    endtask

    task automatic rd(input logic [1:0] a, output logic [15:0] v);
        addr = (16'($urandom) & 16'hFFFC) | {14'd0, a};
        we = 1'b0;
        @(negedge clk);
        v = dout;
        $display("rd  a=%0d -> %h", a, v);
    endtask

    // kind: 0 good frame, 1 stop bit low, 2 one-cycle glitch (false start)
    task automatic rx_frame(input logic [7:0] b, input int kind);
        int d;
        d = int'(m_div);
        rx_active = 1;
        $display("rx  byte=%h kind=%0d div=%0d", b, kind, d);
        if (kind == 2) begin
            rx = 1'b0; @(negedge clk); rx = 1'b1;
            repeat (2*d + 4) @(negedge clk);
        end else begin
            rx = 1'b0; repeat (d) @(negedge clk);
            for (int i = 0; i < 8; i++) begin rx = b[i]; repeat (d) @(negedge clk); end
            rx = (kind == 0); repeat (d) @(negedge clk);
            rx = 1'b1; repeat (4) @(negedge clk);
        end
        rx_done_q.push_back((kind << 8) | int'(b));
        rx_active = 0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog t=%0t got=running exp=finished", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] v;
        logic [9:0]  seq55;
        logic [7:0]  rb;
        int lows;
        idle(3);
        #2 rst_n = 1'b1;
        @(negedge clk);
        check("reset_tx", {15'd0, tx_line}, 16'h0001);
        rd(2'd0, v); check("reset_status", v, 16'h0001);
        rd(2'd3, v); check("reset_divisor", v, 16'h0004);

        // single frame, upper byte ignored
        seq55 = 10'b1010101010;
        wr(2'd1, 16'h0155);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            check("tx_frame55", {15'd0, tx_line}, {15'd0, seq55[i/4]});
        end
        @(negedge clk);
        check("tx_idle55", {15'd0, tx_line}, 16'h0001);

        // back-to-back frames, third write dropped
        wr(2'd1, 16'h00A5);
        fork
            begin
                for (int i = 0; i < 80; i++) begin
                    @(negedge clk);
                    if (i < 40) check("tx_a5", {15'd0, tx_line}, {15'd0, fbit(8'hA5, i/4)});
                    else        check("tx_3c", {15'd0, tx_line}, {15'd0, fbit(8'h3C, (i-40)/4)});
                end
            end
            begin
                idle(1);
                wr(2'd1, 16'h003C);
                wr(2'd1, 16'h00FF);
                rd(2'd0, v); check("status_full", v, 16'h0008);
            end
        join
        lows = 0;
        for (int i = 0; i < 48; i++) begin @(negedge clk); if (!tx_line) lows++; end
        check("tx_no_ff", 16'(lows), 16'd0);

        // receive two bytes
        rx_frame(8'h41, 0);
        rx_frame(8'h42, 0);
        idle(1);
        rd(2'd0, v); check("rx_status2", v, 16'h0203);
        rd(2'd2, v); check("rx_head41", v, 16'h0041);
        wr(2'd2, 16'h0000);
        rd(2'd2, v); check("rx_head42", v, 16'h0042);
        wr(2'd2, 16'h0000);
        rd(2'd2, v); check("rx_empty", v, 16'h0000);

        // overrun, then framing error
        for (int i = 0; i < 5; i++) rx_frame(8'h10 + 8'(i), 0);
        idle(1);
        rd(2'd0, v); check("ovr_status", v, 16'h0407);
        wr(2'd0, 16'h0004);
        rd(2'd0, v); check("ovr_clear", v, 16'h0403);
        rx_frame(8'h77, 1);
        idle(1);
        rd(2'd0, v); check("ferr_status", v, 16'h0413);
        wr(2'd0, 16'h0014);
        for (int i = 0; i < 4; i++) begin
            rd(2'd2, v); check("ovr_head", v, 16'h0010 + 16'(i));
            wr(2'd2, 16'h0000);
        end
        rd(2'd0, v); check("drained", v, 16'h0001);

        // reset mid-frame
        wr(2'd3, 16'd6);
        wr(2'd1, 16'h0000);
        idle(10);
        #2 rst_n = 1'b0;
        #1 check("rst_tx", {15'd0, tx_line}, 16'h0001);
        check("rst_dout", dout, 16'h0000);
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        rd(2'd0, v); check("rst_status", v, 16'h0001);
        rd(2'd3, v); check("rst_divisor", v, 16'h0004);

        // divisor clamp
        wr(2'd3, 16'd1);
        rd(2'd3, v); check("div_clamp", v, 16'h0002);
        wr(2'd1, 16'h0081);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("tx_div2", {15'd0, tx_line}, {15'd0, fbit(8'h81, i/2)});
        end
        idle(4);

        // randomized traffic
        for (int it = 0; it < 70; it++) begin
            int op;
            op = $urandom_range(0, 9);
            case (op)
                0, 1: rd(2'($urandom), v);
                2, 3: wr(2'd1, 16'($urandom));
                4: wr(2'd2, 16'($urandom));
                5: wr(2'd0, 16'($urandom));
                6: begin
                    if (m_line.size() == 0 && !m_hold_full) wr(2'd3, 16'($urandom_range(0, 9)));
                    else idle(1);
                end
                7, 8: begin
                    int r, kind;
                    r = $urandom_range(0, 7);
                    kind = (r == 0) ? 2 : (r == 1) ? 1 : 0;
                    rb = 8'($urandom);
                    rx_active = 1;
                    fork
                        rx_frame(rb, kind);
                        begin
                            while (rx_active) begin
                                int o;
                                o = $urandom_range(0, 3);
                                if (o == 0)      wr(2'd1, 16'($urandom));
                                else if (o == 1) idle($urandom_range(1, 6));
                                else             rd(2'($urandom), v);
                            end
                        end
                    join
                end
                default: idle($urandom_range(1, 20));
            endcase
        end
        idle(220);
        rd(2'd0, v);
        check("final_tx_idle", v & 16'h0009, 16'h0001);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
